fifo_drain_reader: RTL and testbench

//  Read-side master for async_fifo, in the clk_rdd (pop) domain. It pops words from the FIFO

---
 rtl/fifo_drain_reader.sv | 160 ++++++++++++++++
 tb/tb_fifo_drain_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_reader.sv
// fifo_drain_reader
//   Pop-side master for async_fifo, running entirely in the clk_rdd domain.
//   While a drain job is active it pops words whenever the skid buffer has
//   room, counting both buffered words and the pop still in flight. Popped
//   words land in a small skid buffer one cycle after the pop. The buffer
//   feeds a valid/ready output stream.
//
//   A job drains either a fixed number of words (cfg_len != 0) or runs until
//   cfg_stop (cfg_len == 0). After the last pop the job flushes: it waits
//   for the in-flight word to land and for the buffer to empty. It then
//   returns to IDLE and pulses done.
//
// Ports
//   clk_rdd, rst      read-domain clock; asynchronous active-high reset
//   cfg_start         pulse: start a job (only honoured in IDLE)
//   cfg_len           job length in words, 0 = continuous
//   cfg_stop          pulse: end a continuous/fixed job early (DRAIN only)
//   fifo_empty        async_fifo empty flag
//   fifo_data         async_fifo read data, valid the cycle after a pop
//   fifo_pop          pop request (combinational)
//   m_valid/m_ready   downstream handshake
//   m_data            head of skid buffer
//   busy              job in DRAIN or FLUSH
//   done              one-cycle pulse when a job completes
//   words_done        pops issued in the current/last job
module fifo_drain_reader #(
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2,
  parameter int LEN_W     = 8
) (
  input  logic              clk_rdd,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_stop,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_pop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  words_done
);

  localparam int AW = $clog2(BUF_DEPTH);
  // One extra bit so occ can represent a completely full buffer.
  localparam int OW = AW + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t                          state_q, state_d;
  logic [LEN_W-1:0]                len_q, len_d;
  logic [LEN_W-1:0]                wd_q, wd_d;
  logic                            inflight_q, inflight_d;
  logic                            done_q, done_d;
  logic [OW-1:0]                   occ_q, occ_d;
  logic [AW-1:0]                   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [BUF_DEPTH-1:0][DATA_W-1:0] skid_q, skid_d;

  logic             len_hit;
  logic             room;
  logic             xfer;
  logic             last_pop;
  logic [LEN_W-1:0] wd_inc;

  // Pop qualification and stream view of the buffer.
  always_comb begin
    len_hit  = (len_q != '0) && (wd_q == len_q);
    // The in-flight word has already been committed to a buffer slot.
    room     = (occ_q + OW'(inflight_q)) < OW'(BUF_DEPTH);
    fifo_pop = (state_q == DRAIN) && !fifo_empty && room && !len_hit;
    m_valid  = (occ_q != '0);
    m_data   = skid_q[rd_ptr_q];
    xfer     = m_valid && m_ready;
    wd_inc   = wd_q + LEN_W'(1);
    last_pop = fifo_pop && (len_q != '0) && (wd_inc == len_q);
  end

  // Skid buffer: capture the word popped last cycle, retire head on transfer.
  always_comb begin
    skid_d     = skid_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    inflight_d = fifo_pop;
    if (inflight_q) begin
      skid_d[wr_ptr_q] = fifo_data;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    if (xfer) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({inflight_q, xfer})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Job control.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wd_d    = wd_q;
    done_d  = 1'b0;
    // Saturate rather than wrap on long continuous jobs.
    if (fifo_pop && (wd_q != '1)) wd_d = wd_inc;
    case (state_q)
      IDLE: begin
        // Start takes priority over a coincident stop; stop is meaningless here.
        if (cfg_start) begin
          state_d = DRAIN;
          len_d   = cfg_len;
          wd_d    = '0;
        end
      end
      DRAIN: begin
        // A pop in the stop cycle still goes out and is still delivered.
        if (last_pop || cfg_stop) state_d = FLUSH;
      end
      FLUSH: begin
        if (!inflight_q && (occ_q == '0)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_rdd or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      wd_q       <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wd_q       <= wd_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      skid_q     <= skid_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign words_done = wd_q;

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Bench for fifo_drain_reader: a queue-backed async_fifo model feeds the DUT,
// directed jobs push their expected output words into a scoreboard queue, and
// a separate monitor pops and compares on every downstream transfer.
module tb_fifo_drain_reader;
  localparam int DATA_W    = 32;
  localparam int BUF_DEPTH = 2;
  localparam int LEN_W     = 8;

  logic              clk_rdd = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_start = 1'b0;
  logic              cfg_stop = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data = '0;
  logic              fifo_pop;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  words_done;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int pop_cnt = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic flush_fifo = 1'b0;
  logic [DATA_W-1:0] fmem [64];
  logic [DATA_W-1:0] exp_q [$];

  assign fifo_empty = (rd_cnt == wr_cnt);

  fifo_drain_reader #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH), .LEN_W(LEN_W)) dut (
    .clk_rdd(clk_rdd), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .cfg_stop(cfg_stop), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done), .words_done(words_done)
  );

  initial forever #5 clk_rdd = ~clk_rdd;

  // async_fifo read side: data appears the cycle after an accepted pop.
  initial forever begin
    @(posedge clk_rdd);
    if (flush_fifo) rd_cnt <= wr_cnt;
    else if (fifo_pop && !fifo_empty) begin
      fifo_data <= fmem[rd_cnt[5:0]];
      rd_cnt    <= rd_cnt + 1;
      pop_cnt   <= pop_cnt + 1;
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk_rdd);
      if (!rst) begin
        if (done) done_cnt++;
        if (fifo_pop && fifo_empty) begin
          vectors++; miscompares++;
          $display("FAIL pop_on_empty: fifo_pop=1 while fifo_empty=1 at %0t", $time);
        end
        if (m_valid && m_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL stream_extra: got word %0d, expected none", m_data);
          end else begin
            e = exp_q.pop_front();
            if (m_data !== e) begin
              miscompares++;
              $display("FAIL stream_data: got %0d, expected %0d", m_data, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_rdd);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    fmem[wr_cnt[5:0]] = v;
    wr_cnt++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic start(input int len, input logic stop);
    cfg_len = LEN_W'(len); cfg_start = 1'b1; cfg_stop = stop;
    tick();
    cfg_start = 1'b0; cfg_stop = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 80) begin
      tick();
      n++;
    end
    chk({name, "_done_seen"}, 32'(done_cnt != d0), 1);
  endtask

  task automatic flush();
    flush_fifo = 1'b1;
    tick();
    flush_fifo = 1'b0;
  endtask

  initial begin
    int p0, p1, d0;
    logic stopped;

    // Power-on reset state
    tick();
    chk("por_pop", 32'(fifo_pop), 0);
    chk("por_valid", 32'(m_valid), 0);
    chk("por_data", m_data, 0);
    chk("por_busy", 32'(busy), 0);
    chk("por_done", 32'(done), 0);
    chk("por_words", 32'(words_done), 0);
    rst = 1'b0;
    tick();

    // Fixed job of 3 from a FIFO holding 1..5
    for (int i = 1; i <= 5; i++) push(32'(i));
    for (int i = 1; i <= 3; i++) exp_q.push_back(32'(i));
    m_ready = 1'b1; p0 = pop_cnt; d0 = done_cnt;
    start(3, 1'b0);
    wait_done("fixed");
    tick(3);
    chk("fixed_pops", 32'(pop_cnt - p0), 3);
    chk("fixed_done_cnt", 32'(done_cnt - d0), 1);
    chk("fixed_words", 32'(words_done), 3);
    chk("fixed_left", 32'(wr_cnt - rd_cnt), 2);
    chk("fixed_sb", 32'(exp_q.size()), 0);
    flush();

    // Backpressure: buffer fills and holds its head
    for (int i = 11; i <= 14; i++) begin push(32'(i)); exp_q.push_back(32'(i)); end
    m_ready = 1'b0; p0 = pop_cnt; d0 = done_cnt;
    start(4, 1'b0);
    tick(8);
    chk("bp_pops", 32'(pop_cnt - p0), BUF_DEPTH);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_head", m_data, 11);
    tick(3);
    chk("bp_hold", m_data, 11);
    chk("bp_pops_hold", 32'(pop_cnt - p0), BUF_DEPTH);
    m_ready = 1'b1;
    wait_done("bp");
    tick(2);
    chk("bp_pops_total", 32'(pop_cnt - p0), 4);
    chk("bp_done_cnt", 32'(done_cnt - d0), 1);
    chk("bp_sb", 32'(exp_q.size()), 0);

    // Empty stall in the middle of a job
    push(7);
    for (int i = 7; i <= 10; i++) exp_q.push_back(32'(i));
    p0 = pop_cnt; d0 = done_cnt;
    start(4, 1'b0);
    tick(3);
    chk("stall_first", 32'(pop_cnt - p0), 1);
    p1 = pop_cnt;
    tick(5);
    chk("stall_nopop", 32'(pop_cnt - p1), 0);
    chk("stall_busy", 32'(busy), 1);
    for (int i = 8; i <= 10; i++) push(32'(i));
    wait_done("stall");
    tick(2);
    chk("stall_pops", 32'(pop_cnt - p0), 4);
    chk("stall_done_cnt", 32'(done_cnt - d0), 1);
    chk("stall_sb", 32'(exp_q.size()), 0);

    // Continuous job stopped together with the 12th pop
    for (int i = 100; i < 120; i++) push(32'(i));
    for (int i = 100; i < 112; i++) exp_q.push_back(32'(i));
    p0 = pop_cnt; d0 = done_cnt; stopped = 1'b0;
    start(0, 1'b0);
    for (int n = 0; n < 200 && !stopped; n++) begin
      @(negedge clk_rdd);
      if ((pop_cnt - p0 == 11) && fifo_pop) begin
        cfg_stop = 1'b1;
        stopped = 1'b1;
      end
    end
    tick();
    cfg_stop = 1'b0;
    chk("cont_stop_issued", 32'(stopped), 1);
    wait_done("cont");
    chk("cont_valid_at_done", 32'(m_valid), 0);
    tick(2);
    chk("cont_pops", 32'(pop_cnt - p0), 12);
    chk("cont_words", 32'(words_done), 12);
    chk("cont_done_cnt", 32'(done_cnt - d0), 1);
    chk("cont_sb", 32'(exp_q.size()), 0);
    flush();

    // Ignored commands: stop in IDLE, start+stop together, start while busy
    for (int i = 30; i <= 32; i++) push(32'(i));
    p0 = pop_cnt; d0 = done_cnt;
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    tick(3);
    chk("idle_stop_busy", 32'(busy), 0);
    chk("idle_stop_pops", 32'(pop_cnt - p0), 0);
    exp_q.push_back(30); exp_q.push_back(31);
    start(2, 1'b1);
    chk("startwins_busy", 32'(busy), 1);
    start(5, 1'b0);
    wait_done("ign");
    tick(3);
    chk("ign_pops", 32'(pop_cnt - p0), 2);
    chk("ign_words", 32'(words_done), 2);
    chk("ign_done_cnt", 32'(done_cnt - d0), 1);
    chk("ign_left", 32'(wr_cnt - rd_cnt), 1);
    chk("ign_sb", 32'(exp_q.size()), 0);
    flush();

    // Reset mid-DRAIN with two words buffered
    for (int i = 40; i <= 45; i++) push(32'(i));
    m_ready = 1'b0; p0 = pop_cnt;
    start(0, 1'b0);
    tick(6);
    chk("rst_pre_valid", 32'(m_valid), 1);
    chk("rst_pre_pops", 32'(pop_cnt - p0), 2);
    rst = 1'b1;
    #1;
    chk("rst_pop", 32'(fifo_pop), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_words", 32'(words_done), 0);
    tick(2);
    rst = 1'b0;
    flush();
    m_ready = 1'b1;
    tick(5);
    chk("rst_post_valid", 32'(m_valid), 0);
    chk("rst_post_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
